// File: rtl/freq_meas_pkg.sv
// Shared definitions for the divider/meter family: measurement FSM states
// and the default counter width.
package freq_meas_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } meas_state_e;

endpackage : freq_meas_pkg

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with rise/fall
// detection on the synchronized copy.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    // Shift the raw input through the synchronizer chain and keep a delayed copy.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value.
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

endmodule : sync_edge_det

// File: rtl/freq_period_meter.sv
// Measures period and high time of a slow periodic level in clk cycles,
// publishing one result per input period with a single-cycle strobe and
// flagging inputs that stop toggling.
module freq_period_meter
    import freq_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hi_lat_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             period_valid_q;
    logic             timeout_q;
    meas_state_e      state_q;

    // The synchronized level itself is not needed here, only its edges.
    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .s      (),
        .rise   (rise),
        .fall   (fall)
    );

    // Next counter value: restart on a rising edge, otherwise saturating increment.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q + CNT_ONE;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end
    end

    // Cycle counter since the last rising edge; runs regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Capture the elapsed count at the falling edge as the high time.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_lat_q <= '0;
        end else if (fall) begin
            hi_lat_q <= cnt_q;
        end
    end

    // Measurement FSM with registered result, strobe and timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (!en) begin
                state_q   <= ST_IDLE;
                timeout_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_q <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        // A rise coinciding with saturation is still a valid period.
                        if (rise) begin
                            period_q       <= cnt_q;
                            high_time_q    <= hi_lat_q;
                            period_valid_q <= 1'b1;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q   <= ST_TIMEOUT;
                            timeout_q <= 1'b1;
                        end
                    end
                    ST_TIMEOUT: begin
                        // The interval ending here is unknown, so re-arm silently.
                        if (rise) begin
                            state_q   <= ST_MEASURE;
                            timeout_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule : freq_period_meter
